// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants, state encoding and word assembly for the instruction memory loader
package imem_pkg;

    localparam int IW     = 21;
    localparam int HI_MSB = 20;
    localparam int HI_LSB = 16;
    localparam int HI_W   = HI_MSB - HI_LSB + 1;

    // Bits of the first byte that have no home in the 21-bit word.
    localparam logic [7:0] ERR_MASK = 8'hE0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Joins the three byte fields MSB first into one instruction word.
    function automatic logic [IW-1:0] assemble_word(
        input logic [HI_W-1:0] hi,
        input logic [7:0]      mid,
        input logic [7:0]      lo
    );
        logic [IW-1:0] w;
        w                = '0;
        w[HI_MSB:HI_LSB] = hi;
        w[15:8]          = mid;
        w[7:0]           = lo;
        return w;
    endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - instruction storage with asynchronous read and synchronous write
module imem_array #(
    parameter int AW = 8,
    parameter int IW = 21
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [IW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [IW-1:0] rd
);

    // Contents survive reset on purpose: a reset mid-load keeps earlier words.
    logic [IW-1:0] mem [2**AW];

    // Single write port, updated on the rising edge that ends the write cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // Fetch port reads the array directly so the CPU sees writes the edge they land.
    assign rd = mem[ra];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - writable instruction memory with a byte-serial program loader
module imem_loader
    import imem_pkg::*;
#(
    parameter int AW = 8,
    parameter int IW = imem_pkg::IW
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic [AW-1:0] Addr,
    output logic [IW-1:0] INS,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW-1:0] ld_len,
    input  logic [7:0]    ld_byte,
    input  logic          ld_valid,
    output logic          ld_ready,
    output logic          busy,
    output logic          ld_done,
    output logic          ld_err
);

    state_t          state_q, state_d;
    logic [AW-1:0]   wp_q, wp_d;
    logic [AW-1:0]   rem_q, rem_d;
    logic [HI_W-1:0] hi_q, hi_d;
    logic [7:0]      mid_q, mid_d;
    logic [7:0]      lo_q, lo_d;
    logic            err_q, err_d;

    logic            xfer;
    logic            mem_we;
    logic [IW-1:0]   mem_wd;

    // Byte acceptance is decoded from state only, so no input reaches ld_ready.
    assign ld_ready = (state_q == ST_B0) || (state_q == ST_B1) || (state_q == ST_B2);
    assign busy     = (state_q != ST_IDLE);
    assign ld_done  = (state_q == ST_DONE);
    assign ld_err   = err_q;
    assign xfer     = ld_valid && ld_ready;

    assign mem_we = (state_q == ST_WR);
    assign mem_wd = assemble_word(hi_q, mid_q, lo_q);

    // State, pointer, counter and assembly register updates.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            wp_q    <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            mid_q   <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            mid_q   <= mid_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: collect three bytes, write, repeat until the count runs out.
    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        mid_d   = mid_q;
        lo_d    = lo_q;
        err_d   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d = ST_B0;
                    wp_d    = ld_base;
                    rem_d   = ld_len;
                    err_d   = 1'b0;
                end
            end
            ST_B0: begin
                if (xfer) begin
                    state_d = ST_B1;
                    hi_d    = ld_byte[HI_W-1:0];
                    if ((ld_byte & ERR_MASK) != 8'h00) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_B1: begin
                if (xfer) begin
                    state_d = ST_B2;
                    mid_d   = ld_byte;
                end
            end
            ST_B2: begin
                if (xfer) begin
                    state_d = ST_WR;
                    lo_d    = ld_byte;
                end
            end
            ST_WR: begin
                // A length of 0 wraps to all ones here, giving a full-depth load.
                wp_d    = wp_q + AW'(1);
                rem_d   = rem_q - AW'(1);
                state_d = (rem_q == AW'(1)) ? ST_DONE : ST_B0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    imem_array #(
        .AW (AW),
        .IW (IW)
    ) u_array (
        .clk (CLK),
        .we  (mem_we),
        .wa  (wp_q),
        .wd  (mem_wd),
        .ra  (Addr),
        .rd  (INS)
    );

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for the instruction memory loader
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic [7:0]  Addr;
    logic [20:0] INS;
    logic        ld_start;
    logic [7:0]  ld_base;
    logic [7:0]  ld_len;
    logic [7:0]  ld_byte;
    logic        ld_valid;
    logic        ld_ready;
    logic        busy;
    logic        ld_done;
    logic        ld_err;

    imem_loader #(.AW(8), .IW(21)) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .Addr     (Addr),
        .INS      (INS),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_len   (ld_len),
        .ld_byte  (ld_byte),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .busy     (busy),
        .ld_done  (ld_done),
        .ld_err   (ld_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int    done_cyc;
        logic  err;
        string name;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic expect_idle = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ld_done pulse is matched against the oldest expected load.
    always @(negedge CLK) begin
        exp_t e;
        if (expect_idle) begin
            chk("busy_after_done", {31'd0, busy}, 32'd0);
            expect_idle <= 1'b0;
        end
        if (reset_n && ld_done) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got ld_done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_done_cycle"}, cyc, e.done_cyc);
                chk({e.name, "_err"}, {31'd0, ld_err}, {31'd0, e.err});
                expect_idle <= 1'b1;
            end
        end
    end

    task automatic start_load(input string name, input int base, input int len,
                              input int words, input int stalls, input logic err, input bit track);
        exp_t e;
        @(negedge CLK);
        ld_start = 1'b1;
        ld_base  = 8'(base);
        ld_len   = 8'(len);
        if (track) begin
            e.done_cyc = cyc + 4 * words + 1 + stalls;
            e.err      = err;
            e.name     = name;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1 ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge CLK);
        while (!ld_ready && n < 40) begin
            ld_valid = 1'b0;
            n++;
            @(negedge CLK);
        end
        if (!ld_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got ld_ready=0 expected 1 within 40 cycles");
        end
        ld_valid = 1'b1;
        ld_byte  = b;
        @(posedge CLK);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        ld_valid = 1'b0;
        while (busy && n < 100) begin
            n++;
            @(negedge CLK);
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: got busy=1 expected 0 within 100 cycles");
        end
    endtask

    task automatic chk_mem(input string name, input logic [7:0] a, input logic [20:0] exp);
        @(negedge CLK);
        Addr = a;
        #1 chk(name, {11'd0, INS}, {11'd0, exp});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        Addr     = 8'd0;
        ld_start = 1'b0;
        ld_base  = 8'd0;
        ld_len   = 8'd0;
        ld_byte  = 8'd0;
        ld_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_busy",  {31'd0, busy},     32'd0);
        chk("rst_done",  {31'd0, ld_done},  32'd0);
        chk("rst_err",   {31'd0, ld_err},   32'd0);
        @(negedge CLK);
        reset_n = 1'b1;

        // Two words back-to-back from address 0.
        start_load("basic", 0, 2, 2, 0, 1'b0, 1'b1);
        send_byte(8'h0B); send_byte(8'h80); send_byte(8'hFF);
        send_byte(8'h0C); send_byte(8'h00); send_byte(8'h05);
        wait_idle();
        chk_mem("basic_w0", 8'd0, 21'h0B80FF);
        chk_mem("basic_w1", 8'd1, 21'h0C0005);

        // Write pointer wraps from 255 to 0.
        start_load("wrap", 255, 2, 2, 0, 1'b0, 1'b1);
        send_byte(8'h1A); send_byte(8'h2B); send_byte(8'h3C);
        send_byte(8'h1F); send_byte(8'h01); send_byte(8'h02);
        wait_idle();
        chk_mem("wrap_w255", 8'd255, 21'h1A2B3C);
        chk_mem("wrap_w0",   8'd0,   21'h1F0102);
        chk_mem("wrap_w1",   8'd1,   21'h0C0005);

        // Three-cycle stall in B1 with a stray ld_start while busy.
        start_load("stall", 20, 1, 1, 3, 1'b0, 1'b1);
        send_byte(8'h15);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            ld_valid = 1'b0;
            ld_start = (i == 0);
            ld_base  = 8'd100;
            ld_len   = 8'd5;
            #1 chk("stall_ready", {31'd0, ld_ready}, 32'd1);
        end
        ld_start = 1'b0;
        send_byte(8'hAA); send_byte(8'h55);
        wait_idle();
        chk_mem("stall_word", 8'd20, 21'h15AA55);

        // Malformed first byte: flag set, upper bits dropped.
        start_load("errbyte", 30, 1, 1, 0, 1'b1, 1'b1);
        send_byte(8'hEB); send_byte(8'h12); send_byte(8'h34);
        wait_idle();
        chk("err_sticky", {31'd0, ld_err}, 32'd1);
        chk_mem("err_word", 8'd30, 21'h0B1234);

        // Overwrite the same address while fetching it across the write cycle.
        @(negedge CLK);
        Addr = 8'd30;
        start_load("fetchwr", 30, 1, 1, 0, 1'b0, 1'b1);
        chk("err_cleared", {31'd0, ld_err}, 32'd0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        #1 chk("ins_wr_start", {11'd0, INS}, {11'd0, 21'h0B1234});
        @(negedge CLK);
        chk("ins_wr_mid", {11'd0, INS}, {11'd0, 21'h0B1234});
        @(posedge CLK);
        #1 chk("ins_after_wr", {11'd0, INS}, {11'd0, 21'h010203});
        wait_idle();

        // Reset during B1 of the second of three words.
        start_load("rstmid", 0, 3, 3, 0, 1'b0, 1'b0);
        send_byte(8'h07); send_byte(8'h08); send_byte(8'h09);
        send_byte(8'h11);
        @(negedge CLK);
        ld_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("rstmid_ready", {31'd0, ld_ready}, 32'd0);
        chk("rstmid_busy",  {31'd0, busy},     32'd0);
        chk("rstmid_done",  {31'd0, ld_done},  32'd0);
        chk("rstmid_err",   {31'd0, ld_err},   32'd0);
        chk("rstmid_wp",    {24'd0, dut.wp_q},  32'd0);
        chk("rstmid_rem",   {24'd0, dut.rem_q}, 32'd0);
        @(negedge CLK);
        reset_n = 1'b1;
        chk_mem("rstmid_w0", 8'd0, 21'h070809);
        chk_mem("rstmid_w1", 8'd1, 21'h0C0005);

        repeat (3) @(negedge CLK);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL pending_loads: got %0d outstanding expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
